// File: rtl/tt_serial_pkg.sv
// Shared types and pin map for the bit-serial add/subtract sequencer.
package tt_serial_pkg;
  localparam int WIDTH = 4;
  localparam int BIT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // uio_in pin indices
  localparam int START_PIN = 0;
  localparam int SUB_PIN   = 1;

  // uo_out pin indices; result occupies [WIDTH-1:0]
  localparam int CARRY_PIN = 4;
  localparam int BUSY_PIN  = 5;
  localparam int DONE_PIN  = 6;
  localparam int OV_PIN    = 7;
endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder, purely combinational; shared across all bit positions.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/tt_um_serial_adder_ctrl.sv
// Bit-serial add/subtract over one full-adder cell, LSB first; done WIDTH cycles after capture.
// Start/busy/done handshake; start held high parks the FSM in DONE so one op runs per assertion.
module tt_um_serial_adder_ctrl
  import tt_serial_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [BIT_W-1:0] bit_q;
  logic             carry_q, ov_q;
  logic [3:0]       cnt_q;

  logic start, sub;
  logic capture, shift, last;
  logic busy, done;
  logic fa_sum, fa_cout;
  logic unused_pins;

  assign start       = uio_in[START_PIN];
  assign sub         = uio_in[SUB_PIN];
  assign unused_pins = &{1'b0, uio_in[7:2]};

  full_adder_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)   state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (bit_q == LAST_BIT) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = (state_q == IDLE) && start;
    shift   = (state_q == RUN);
    last    = shift && (bit_q == LAST_BIT);
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
  end

  // Subtraction is A + ~B + 1: invert B at capture and seed the carry with sub.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (ena) begin
      if (capture) begin
        a_q     <= ui_in[3:0];
        b_q     <= sub ? ~ui_in[7:4] : ui_in[7:4];
        carry_q <= sub;
        bit_q   <= '0;
        res_q   <= '0;
      end else if (shift) begin
        res_q   <= {fa_sum, res_q[WIDTH-1:1]};
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        carry_q <= fa_cout;
        bit_q   <= bit_q + 1'b1;
        if (last) begin
          // carry_q here is the carry into the MSB
          ov_q  <= carry_q ^ fa_cout;
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    uo_out              = 8'h00;
    uo_out[WIDTH-1:0]   = res_q;
    uo_out[CARRY_PIN]   = carry_q;
    uo_out[BUSY_PIN]    = busy;
    uo_out[DONE_PIN]    = done;
    uo_out[OV_PIN]      = ov_q;
    uio_out             = {cnt_q, 4'b0000};
    uio_oe              = 8'hF0;
  end
endmodule

// File: tb/tb_tt_um_serial_adder_ctrl.sv
// Directed self-checking bench for the bit-serial add/subtract sequencer.
module tb_tt_um_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  tt_um_serial_adder_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!uo_out[6] && cycles < 30) begin
      tick(1);
      cycles++;
    end
  endtask

  // One full operation: capture, run to DONE, check, release start to IDLE.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [3:0] er, input logic ec, input logic eov);
    int cyc;
    ui_in  = {b, a};
    uio_in = {6'b0, s, 1'b1};
    tick(1);
    check({tag, "_busy"}, uo_out[5], 1'b1);
    uio_in = {6'b0, ~s, 1'b0};
    wait_done(cyc);
    exp_cnt = (exp_cnt + 1) % 16;
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_res"}, uo_out[3:0], er);
    check({tag, "_carry"}, uo_out[4], ec);
    check({tag, "_ov"}, uo_out[7], eov);
    check({tag, "_cnt"}, uio_out, {exp_cnt[3:0], 4'b0000});
    tick(1);
    check({tag, "_idle"}, uo_out, {eov, 2'b00, ec, er});
  endtask

  initial begin
    int cyc;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    tick(2);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    rst_n  = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    tick(1);
    check("idle_uo", uo_out, 8'h00);

    do_op("add3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
    do_op("add9_8", 4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b1);
    do_op("sub5_3", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
    do_op("sub3_5", 4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0);

    // Reset arriving at bit index 2 discards the partial op
    ui_in  = 8'h17;
    uio_in = 8'h01;
    tick(1);
    uio_in = 8'h00;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_cnt = 0;
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_cnt", uio_out, 8'h00);

    // Start held high: exactly one op, FSM parks in DONE
    ui_in  = 8'h17;
    uio_in = 8'h01;
    tick(20);
    exp_cnt = 1;
    check("hold_uo", uo_out, 8'hC8);
    check("hold_cnt", uio_out, 8'h10);
    uio_in = 8'h00;
    tick(1);
    check("hold_release", uo_out, 8'h88);

    // Freeze mid-RUN for 3 cycles, start/sub toggled meanwhile
    ui_in  = 8'h76;
    uio_in = 8'h01;
    tick(1);
    uio_in = 8'h00;
    tick(1);
    ena    = 1'b0;
    uio_in = 8'h03;
    tick(3);
    check("ena_frozen_busy", uo_out[6:5], 2'b01);
    ena    = 1'b1;
    uio_in = 8'h00;
    wait_done(cyc);
    exp_cnt = 2;
    check("ena_lat", cyc, 3);
    check("ena_uo", uo_out, 8'hCD);
    check("ena_cnt", uio_out, 8'h20);
    tick(1);

    // Counter wrap at minimum period
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      ui_in  = {4'(15 - i), 4'(i)};
      uio_in = 8'h01;
      tick(1);
      uio_in = 8'h00;
      tick(4);
      exp_cnt = (exp_cnt + 1) % 16;
      if (i == 14) check("wrap_cnt15", uio_out, 8'hF0);
      if (i == 15) begin
        check("wrap_res", uo_out[6:0], 7'h4F);
        check("wrap_cnt0", uio_out, 8'h00);
      end
      tick(1);
    end
    check("wrap_idle_done", uo_out[6], 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
